// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding and default width.
package seq_divider_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

endpackage

// File: rtl/cla_subtractor.sv
// N-bit subtractor a - b built as a + ~b + 1 from generate/propagate terms.
module cla_subtractor #(
    parameter int unsigned N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         no_borrow
);

    logic [N-1:0] b_inv;
    logic [N-1:0] gen;
    logic [N-1:0] prop;

    assign b_inv = ~b;
    assign gen   = a & b_inv;
    assign prop  = a ^ b_inv;

    // Carry-in of 1 completes the two's-complement negation of b.
    always_comb begin
        logic carry;
        carry = 1'b1;
        diff  = '0;
        for (int i = 0; i < int'(N); i++) begin
            diff[i] = prop[i] ^ carry;
            carry   = gen[i] | (prop[i] & carry);
        end
        no_borrow = carry;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, WIDTH iterations per result.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             no_borrow;
    logic             unused_rem_msb;

    // The partial remainder never exceeds the divisor, so its top bit stays clear.
    assign unused_rem_msb = rem_q[WIDTH];
    assign shifted        = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};

    cla_subtractor #(
        .N (WIDTH + 1)
    ) u_sub (
        .a         (shifted),
        .b         ({1'b0, divisor_q}),
        .diff      (trial),
        .no_borrow (no_borrow)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        q_d         = q_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    divisor_d = divisor;
                    q_d       = dividend;
                    rem_d     = '0;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    state_d   = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                if (divisor_q == '0) begin
                    // q still holds the untouched dividend on the first RUN cycle.
                    quotient_d  = '1;
                    remainder_d = q_q;
                    dbz_d       = 1'b1;
                    state_d     = StDone;
                end else begin
                    rem_d = no_borrow ? trial : shifted;
                    q_d   = {q_q[WIDTH-2:0], no_borrow};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        quotient_d  = q_d;
                        remainder_d = rem_d[WIDTH-1:0];
                        state_d     = StDone;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == StRun);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver pushes expected results, a monitor checks them on done.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int unsigned  done_cyc;
        int unsigned  busy_len;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned busy_cnt = 0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge; the start is accepted at the following posedge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        exp_t e;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        e.q        = eq;
        e.r        = er;
        e.dbz      = edbz;
        e.busy_len = (b == 0) ? 1 : W;
        e.done_cyc = cyc + 1 + e.busy_len;
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edbz);
        @(negedge clk);
        issue(a, b, eq, er, edbz);
        @(negedge clk);
        start = 1'b0;
        repeat ((b == 0) ? 1 : W) @(negedge clk);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("quotient", 32'(quotient), 32'(e.q));
                    check("remainder", 32'(remainder), 32'(e.r));
                    check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    check("done_cycle", cyc, e.done_cyc);
                    check("busy_cycles", busy_cnt, e.busy_len);
                    check("busy_with_done", 32'(busy), 32'd0);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_quotient", 32'(quotient), 32'd0);
        check("reset_remainder", 32'(remainder), 32'd0);
        check("reset_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;

        run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
        run_op(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1);

        // Next accepted start clears div_by_zero while results hold
        @(negedge clk);
        issue(8'd12, 8'd4, 8'd3, 8'd0, 1'b0);
        @(posedge clk);
        #1;
        check("dbz_cleared", 32'(div_by_zero), 32'd0);
        check("hold_quotient", 32'(quotient), 32'hFF);
        check("busy_after_start", 32'(busy), 32'd1);
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);

        // Start held high: operands changed mid-run are ignored, restart in done cycle
        @(negedge clk);
        issue(8'd200, 8'd3, 8'd66, 8'd2, 1'b0);
        @(negedge clk);
        dividend = 8'd10;
        divisor  = 8'd2;
        repeat (W) @(negedge clk);
        issue(8'd10, 8'd2, 8'd5, 8'd0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (W) @(negedge clk);

        // Reset in RUN cycle 4 aborts with no done
        @(negedge clk);
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 4) @(negedge clk);
        run_op(8'd9, 8'd4, 8'd2, 8'd1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, a / b, a % b, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Sequential unsigned restoring divider: the inverse of the datapath adder. It takes a WIDTH-bit dividend and divisor on a single-cycle start strobe and produces one quotient bit per clock. After WIDTH iterations it presents the quotient and remainder with a one-cycle done pulse. It sits beside the adder/ALU blocks as the multi-cycle divide unit for the core's DIV/REM path.

## Interface

Parameters:
- WIDTH, 8, operand, quotient and remainder width; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  launch request; sampled only when busy==0.
- dividend  input  WIDTH  unsigned dividend; captured with an accepted start.
- divisor  input  WIDTH  unsigned divisor; captured with an accepted start.
- busy  output  1  high while iterating (RUN state).
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.
- div_by_zero  output  1  set with done when the captured divisor==0.

## Operation

- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1:
  - capture divisor;
  - load the quotient shift register with dividend;
  - clear the partial remainder (WIDTH+1 bits);
  - clear the iteration counter;
  - go to RUN.
- IDLE or DONE, start=1, divisor==0: go to RUN anyway and complete in one iteration (see below).
- IDLE, start=0: stay in IDLE.
- DONE, start=0: go to IDLE.
- RUN, each cycle:
  - trial = {rem[WIDTH-1:0], q[WIDTH-1]} − {1'b0, divisor}, computed at WIDTH+1 bits;
  - no borrow: rem←trial, q←{q[WIDTH-2:0],1};
  - borrow: rem←{rem[WIDTH-1:0], q[WIDTH-1]}, q←{q[WIDTH-2:0],0};
  - counter increments; on the cycle where counter==WIDTH-1, go to DONE.
- Divide by zero, handled in RUN on the first cycle:
  - quotient←all ones, remainder←dividend, div_by_zero←1;
  - go to DONE directly.
- start while busy==1 is ignored. Operands are not re-sampled.
- quotient, remainder and div_by_zero hold their values until the next accepted start. An accepted start clears div_by_zero.
- Subtraction is a+~b+1. Carry-out=1 means no borrow.

## Timing

- Reset values (asynchronous, immediate on rst_n low): state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
- Reset mid-operation aborts the operation. No done pulse follows.
- Start accepted at edge T: busy=1 from T until edge T+WIDTH.
- done=1 for exactly one cycle, between edges T+WIDTH and T+WIDTH+1. Latency from start to done is WIDTH+1 cycles including the start cycle.
- Divide by zero: done is high between edges T+1 and T+2.
- busy and done are never high together.
- start in the done cycle is accepted. That gives back-to-back operation with a throughput of one result per WIDTH+1 cycles.

## Structure

- Shared include (divider defines):
  - state encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - default WIDTH.
- One sub-module: cla_subtractor.
  - Parameter N (set to WIDTH+1).
  - Ports: a, b, diff, no_borrow.
  - Internally computes g/p lookahead terms on a and ~b with carry-in 1, so the divide path reuses the team's lookahead scheme.
- seq_divider holds the FSM, counter ($clog2(WIDTH) bits), q/rem registers and the output registers.

## Test plan

- WIDTH=8, dividend=100, divisor=7, start one cycle → done exactly 9 cycles after the start cycle; quotient=14, remainder=2, div_by_zero=0; busy high for 8 cycles.
- dividend=255, divisor=1 → quotient=255, remainder=0. Then dividend=5, divisor=9 → quotient=0, remainder=5.
- dividend=77, divisor=0 → done 2 cycles after start; quotient=8'hFF, remainder=77, div_by_zero=1. The next valid start clears div_by_zero.
- Start 200/3; hold start high and change operands to 10/2 during RUN → the result is still quotient=66, remainder=2. The operation launched by start held in the done cycle yields 10/2 → 5, 0.
- Start 100/7; pulse rst_n low at RUN cycle 4 → all outputs are 0 immediately and no done follows. A fresh start of 9/4 → quotient=2, remainder=1.
- Random sweep of 1,000 operand pairs (WIDTH=8, divisor≠0) → quotient*divisor+remainder==dividend and remainder<divisor on every done.
